// File: rtl/alu_share_arb.sv
// rtl/alu_share_arb.sv - two-requester arbiter sharing one combinational alu32 with a registered response slot
// Round-robin between execute pipe (0) and microsequencer (1); requester 1 may lock the ALU across beats.

module alu_share_arb #(
   parameter logic [31:0] FLAGS_RST = 32'h0000_0002,
   parameter logic        RR_INIT   = 1'b1
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        req0_valid,
   input  logic [2:0]  req0_op,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [2:0]  req1_op,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   input  logic        req1_lock,
   output logic        req1_ready,
   output logic [2:0]  alu_op,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [31:0] alu_flags_in,
   input  logic [31:0] alu_out,
   input  logic [31:0] alu_flags,
   output logic        rsp_valid,
   output logic        rsp_id,
   output logic [31:0] rsp_result,
   output logic [31:0] rsp_flags,
   input  logic        rsp_ready,
   output logic [31:0] flags_q
);

   typedef enum logic {
      ST_RR    = 1'b0,
      ST_LOCK1 = 1'b1
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic        r_last_grant;
   logic        r_rsp_valid;
   logic        r_rsp_id;
   logic [31:0] r_rsp_result;
   logic [31:0] r_rsp_flags;
   logic [31:0] r_flags;
   logic        w_ci;
   logic        w_issue;
   logic        w_gnt_id;
   logic        w_sel1;

   // Gating with RST keeps both readys low during the reset cycle.
   assign w_ci = RST && (!r_rsp_valid || rsp_ready);

   always_comb begin
      w_issue     = 1'b0;
      w_gnt_id    = 1'b0;
      w_state_nxt = r_state;
      case (r_state)
         ST_RR: begin
            if (req0_valid && req1_valid) begin
               w_gnt_id = ~r_last_grant;
               w_issue  = w_ci;
            end else if (req1_valid) begin
               w_gnt_id = 1'b1;
               w_issue  = w_ci;
            end else if (req0_valid) begin
               w_issue  = w_ci;
            end
         end
         ST_LOCK1: begin
            w_gnt_id = 1'b1;
            w_issue  = w_ci && req1_valid;
         end
         default: ;
      endcase
      if (w_issue && w_gnt_id)
         w_state_nxt = req1_lock ? ST_LOCK1 : ST_RR;
   end

   assign w_sel1       = w_issue && w_gnt_id;
   assign req0_ready   = w_issue && !w_gnt_id;
   assign req1_ready   = w_sel1;
   assign alu_op       = w_sel1 ? req1_op : req0_op;
   assign alu_a        = w_sel1 ? req1_a  : req0_a;
   assign alu_b        = w_sel1 ? req1_b  : req0_b;
   assign alu_flags_in = r_flags;

   always_ff @(posedge CLK) begin
      if (!RST) begin
         r_state      <= ST_RR;
         r_last_grant <= RR_INIT;
         r_rsp_valid  <= 1'b0;
         r_rsp_id     <= 1'b0;
         r_rsp_result <= 32'h0;
         r_rsp_flags  <= 32'h0;
         r_flags      <= FLAGS_RST;
      end else begin
         r_state <= w_state_nxt;
         if (w_issue) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_id     <= w_gnt_id;
            r_rsp_result <= alu_out;
            r_rsp_flags  <= alu_flags;
            r_flags      <= alu_flags;
            r_last_grant <= w_gnt_id;
         end else if (rsp_ready) begin
            r_rsp_valid  <= 1'b0;
         end
      end
   end

   assign rsp_valid  = r_rsp_valid;
   assign rsp_id     = r_rsp_id;
   assign rsp_result = r_rsp_result;
   assign rsp_flags  = r_rsp_flags;
   assign flags_q    = r_flags;

endmodule

// File: tb/tb_alu_share_arb.sv
// tb/tb_alu_share_arb.sv - bench for alu_share_arb with a stand-in alu32 and response scoreboard
// Stand-in ALU: op0 ADD, op1 SUB, op2 AND, op3 DAA (AL adjust, AF reported clear), others XOR.

module tb_alu_share_arb;

   logic        CLK = 1'b0;
   logic        RST;
   logic        req0_valid, req1_valid, req1_lock, rsp_ready;
   logic [2:0]  req0_op, req1_op;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic        req0_ready, req1_ready;
   logic [2:0]  alu_op;
   logic [31:0] alu_a, alu_b, alu_flags_in, alu_out, alu_flags;
   logic        rsp_valid, rsp_id;
   logic [31:0] rsp_result, rsp_flags, flags_q;

   int n_checks = 0;
   int n_errors = 0;

   always #5 CLK = ~CLK;

   alu_share_arb dut (
      .CLK(CLK), .RST(RST),
      .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
      .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
      .req1_lock(req1_lock), .req1_ready(req1_ready),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_flags_in(alu_flags_in),
      .alu_out(alu_out), .alu_flags(alu_flags),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
      .rsp_flags(rsp_flags), .rsp_ready(rsp_ready), .flags_q(flags_q)
   );

   function automatic logic [63:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] fin);
      logic [32:0] s;
      logic [31:0] r;
      logic [7:0]  al;
      logic        cf, af, of;
      cf = 1'b0; af = 1'b0; of = 1'b0;
      case (op)
         3'd0: begin
            s = {1'b0, a} + {1'b0, b}; r = s[31:0]; cf = s[32];
            af = a[4] ^ b[4] ^ r[4];
            of = (a[31] == b[31]) && (r[31] != a[31]);
         end
         3'd1: begin
            r = a - b; cf = a < b; af = a[4] ^ b[4] ^ r[4];
            of = (a[31] != b[31]) && (r[31] != a[31]);
         end
         3'd2: r = a & b;
         3'd3: begin
            al = a[7:0];
            if (fin[4] || al[3:0] > 4'd9) al = al + 8'h06;
            if (fin[0] || a[7:0] > 8'h99) begin
               al = al + 8'h60; cf = 1'b1;
            end
            r = {a[31:8], al};
         end
         default: r = a ^ b;
      endcase
      return {(fin & ~32'h0000_08D5) | 32'h2 | {20'h0, of, 3'b0, r[31], (r == 32'h0), 1'b0,
              af, 1'b0, ~^r[7:0], 1'b0, cf}, r};
   endfunction

   assign {alu_flags, alu_out} = ref_alu(alu_op, alu_a, alu_b, alu_flags_in);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard and reference arbitration model, evaluated mid-cycle.
   typedef struct {
      logic        id;
      logic [31:0] res;
      logic [31:0] flg;
   } rsp_t;

   rsp_t        sb_q[$];
   logic [31:0] m_flags = 32'h2;
   logic        m_last = 1'b1;
   logic        m_lock = 1'b0;
   logic        m_rv = 1'b0;

   always @(negedge CLK) begin
      logic ci, g0, g1;
      logic [63:0] rr;
      if (!RST) begin
         chk("ready0_in_reset", {31'h0, req0_ready}, 32'h0);
         chk("ready1_in_reset", {31'h0, req1_ready}, 32'h0);
         m_flags = 32'h2; m_last = 1'b1; m_lock = 1'b0; m_rv = 1'b0;
         sb_q.delete();
      end else begin
         ci = !m_rv || rsp_ready;
         if (m_lock) begin
            g0 = 1'b0; g1 = req1_valid;
         end else if (req0_valid && req1_valid) begin
            g0 = m_last; g1 = !m_last;
         end else begin
            g0 = req0_valid; g1 = req1_valid;
         end
         g0 = g0 && ci; g1 = g1 && ci;
         chk("req0_ready", {31'h0, req0_ready}, {31'h0, g0});
         chk("req1_ready", {31'h0, req1_ready}, {31'h0, g1});
         chk("rsp_valid", {31'h0, rsp_valid}, {31'h0, m_rv});
         chk("flags_q", flags_q, m_flags);
         chk("alu_flags_in", alu_flags_in, m_flags);
         if (rsp_valid) begin
            if (sb_q.size() == 0) begin
               chk("sb_nonempty", 32'h0, 32'h1);
            end else begin
               chk("rsp_id", {31'h0, rsp_id}, {31'h0, sb_q[0].id});
               chk("rsp_result", rsp_result, sb_q[0].res);
               chk("rsp_flags", rsp_flags, sb_q[0].flg);
               if (rsp_ready) void'(sb_q.pop_front());
            end
         end
         if (g0) begin
            rr = ref_alu(req0_op, req0_a, req0_b, m_flags);
            sb_q.push_back('{1'b0, rr[31:0], rr[63:32]});
            m_flags = rr[63:32]; m_last = 1'b0;
         end else if (g1) begin
            rr = ref_alu(req1_op, req1_a, req1_b, m_flags);
            sb_q.push_back('{1'b1, rr[31:0], rr[63:32]});
            m_flags = rr[63:32]; m_last = 1'b1; m_lock = req1_lock;
         end
         if (g0 || g1) m_rv = 1'b1;
         else if (rsp_ready) m_rv = 1'b0;
      end
   end

   typedef struct {
      logic        rst;
      logic        v0;
      logic [2:0]  op0;
      logic [31:0] a0, b0;
      logic        v1;
      logic [2:0]  op1;
      logic [31:0] a1, b1;
      logic        lk, rr, e0, e1;
   } vec_t;

   function automatic vec_t mk(input logic rst, input logic v0, input logic [2:0] op0,
                               input logic [31:0] a0, input logic [31:0] b0, input logic v1,
                               input logic [2:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                               input logic lk, input logic rr, input logic e0, input logic e1);
      return '{rst, v0, op0, a0, b0, v1, op1, a1, b1, lk, rr, e0, e1};
   endfunction

   task automatic step(input vec_t v, input string tag);
      @(posedge CLK);
      #1;
      RST = v.rst; rsp_ready = v.rr; req1_lock = v.lk;
      req0_valid = v.v0; req0_op = v.op0; req0_a = v.a0; req0_b = v.b0;
      req1_valid = v.v1; req1_op = v.op1; req1_a = v.a1; req1_b = v.b1;
      @(negedge CLK);
      chk({tag, "_ready0"}, {31'h0, req0_ready}, {31'h0, v.e0});
      chk({tag, "_ready1"}, {31'h0, req1_ready}, {31'h0, v.e1});
   endtask

   vec_t vec[24];

   initial begin
      RST = 1'b0; rsp_ready = 1'b0; req1_lock = 1'b0;
      req0_valid = 1'b0; req0_op = 3'd0; req0_a = 32'h0; req0_b = 32'h0;
      req1_valid = 1'b0; req1_op = 3'd0; req1_a = 32'h0; req1_b = 32'h0;

      vec[0]  = mk(0, 1, 0, 32'h1, 32'h2, 1, 0, 32'h3, 32'h4, 0, 1, 0, 0);
      vec[1]  = mk(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 1, 0, 0);
      // tie: grant order 0,1,0,1,0,1
      for (int k = 0; k < 6; k++)
         vec[2+k] = mk(1, 1, 3'(k % 3), 32'h1000_0000 * k + 32'h55, 32'h0F0F_0F0F,
                       1, 3'(k % 3 + 1), 32'hFFFF_FFF0 - k, 32'h11 * k, 0, 1,
                       (k % 2 == 0), (k % 2 == 1));
      // backpressure, then issue without bubble
      for (int k = 0; k < 3; k++)
         vec[8+k] = mk(1, 1, 0, 32'h5, 32'h6, 1, 1, 32'h7, 32'h8, 0, 0, 0, 0);
      vec[11] = mk(1, 1, 0, 32'hFFFF_FFFF, 32'h1, 1, 1, 32'h9, 32'hA, 0, 1, 1, 0);
      // lock hold, then unlock hands next grant to requester 0
      for (int k = 0; k < 4; k++)
         vec[12+k] = mk(1, 1, 0, 32'h20, 32'h21, 1, 2, 32'hF0F0 + k, 32'hFF0F, 1, 1, 0, 1);
      vec[16] = mk(1, 1, 0, 32'h20, 32'h21, 1, 1, 32'h100, 32'h1, 0, 1, 0, 1);
      vec[17] = mk(1, 1, 0, 32'h8000_0000, 32'h8000_0000, 1, 1, 32'h2, 32'h3, 0, 1, 1, 0);
      vec[18] = mk(1, 1, 0, 32'h1, 32'h1, 1, 0, 32'h44, 32'h4, 1, 1, 0, 1);
      vec[19] = mk(1, 1, 0, 32'h1, 32'h1, 0, 0, 32'h0, 32'h0, 1, 1, 0, 0);
      vec[20] = mk(1, 1, 0, 32'h1, 32'h1, 1, 0, 32'h45, 32'h5, 1, 1, 0, 1);
      // reset while locked with a response pending
      vec[21] = mk(0, 1, 0, 32'h1, 32'h1, 1, 0, 32'h6, 32'h6, 1, 0, 0, 0);
      vec[22] = mk(1, 1, 0, 32'h30, 32'h3, 1, 0, 32'h7, 32'h7, 0, 1, 1, 0);
      vec[23] = mk(1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 1, 0, 0);

      for (int i = 0; i < 24; i++) step(vec[i], $sformatf("vec%0d", i));

      // single ADD overflow case
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), "rst2");
      step(mk(1, 1, 0, 32'h7FFF_FFFF, 32'h1, 0, 0, 0, 0, 0, 1, 1, 0), "add");
      step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), "add_rsp");
      chk("add_valid", {31'h0, rsp_valid}, 32'h1);
      chk("add_id", {31'h0, rsp_id}, 32'h0);
      chk("add_result", rsp_result, 32'h8000_0000);
      chk("add_of_sf_af_cf", {28'h0, rsp_flags[11], rsp_flags[7], rsp_flags[4], rsp_flags[0]},
          32'hE);

      // DAA depends on the ADD's flags
      step(mk(1, 1, 0, 32'h38, 32'h45, 0, 0, 0, 0, 0, 1, 1, 0), "chain_add");
      step(mk(1, 1, 3, 32'h7D, 32'h0, 0, 0, 0, 0, 0, 1, 1, 0), "chain_daa");
      step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), "chain_rsp");
      chk("daa_result_lo", {24'h0, rsp_result[7:0]}, 32'h83);
      chk("daa_af_cf", {30'h0, rsp_flags[4], rsp_flags[0]}, 32'h0);
      step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), "drain");
      chk("sb_drained", sb_q.size(), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/alu_share_arb.md
ALU_SHARE_ARB -- requirements
Module: alu_share_arb

Interface
REQ-001 Parameter FLAGS_RST, default 32'h0000_0002, value of the architectural flags register after reset.
REQ-002 Parameter RR_INIT, default 1'b1, initial value of last_grant, so requester 0 wins the first tie.
REQ-003 CLK  in  1  single clock; all state updates on posedge CLK.
REQ-004 RST  in  1  reset, synchronous, active-low (RST==0 at posedge CLK resets).
REQ-005 req0_valid  in  1 / req0_op  in  3 / req0_a, req0_b  in  32 each: execute-pipe ALU request.
REQ-006 req0_ready  out  1  request 0 accepted this cycle when req0_valid && req0_ready.
REQ-007 req1_valid  in  1 / req1_op  in  3 / req1_a, req1_b  in  32 each / req1_lock  in  1: microsequencer (REP/string) request.
REQ-008 req1_ready  out  1  request 1 accepted this cycle when req1_valid && req1_ready.
REQ-009 alu_op  out  3 / alu_a, alu_b  out  32 each / alu_flags_in  out  32: drive the shared combinational alu32 (op, a, b, flags).
REQ-010 alu_out  in  32 / alu_flags  in  32: same-cycle alu32 result and updated flags.
REQ-011 rsp_valid  out  1 / rsp_id  out  1 / rsp_result  out  32 / rsp_flags  out  32 / rsp_ready  in  1: registered response channel.
REQ-012 flags_q  out  32  architectural flags register.

Function
REQ-013 Response slot "can issue" (ci) SHALL be !rsp_valid || rsp_ready.
REQ-014 Grant FSM states RR and LOCK1; arbitration SHALL be combinational from current state, valids, ci.
REQ-015 RR: only one valid -> grant it; both valid -> grant the requester != last_grant.
REQ-016 LOCK1: only requester 1 eligible; req0_ready SHALL be 0 even if req1_valid==0.
REQ-017 reqN_ready SHALL be 1 iff ci && requester N is the granted one; no grant when ci==0.
REQ-018 alu_op/alu_a/alu_b SHALL mux the granted requester's fields; when no grant, drive requester 0's fields (don't-care for state).
REQ-019 alu_flags_in SHALL always equal flags_q.
REQ-020 On an accepted request (issue): rsp_result<=alu_out, rsp_flags<=alu_flags, rsp_id<=granted id, flags_q<=alu_flags, last_grant<=granted id, rsp_valid<=1; latency 1 cycle, throughput 1/cycle.
REQ-021 No issue and rsp_valid && rsp_ready -> rsp_valid<=0; no issue and rsp_ready==0 -> all response regs hold.
REQ-022 Drain and issue in same cycle SHALL overwrite slot with rsp_valid staying 1 (no bubble).
REQ-023 RR->LOCK1 on issue of requester 1 with req1_lock==1; LOCK1->RR on issue of requester 1 with req1_lock==0; lock sampled only at issue.
REQ-024 flags_q SHALL change only on issue; back-to-back dependent ops (e.g. DAA op 3 after ADD op 0) SHALL see prior op's flags.
REQ-025 rsp_* SHALL hold stable while rsp_valid && !rsp_ready.
REQ-026 Requester changing fields while valid && !ready is allowed; only values at the issue cycle matter.

Reset
REQ-027 RST==0: rsp_valid=0, rsp_id=0, rsp_result=0, rsp_flags=0, flags_q=FLAGS_RST, last_grant=RR_INIT, FSM=RR.
REQ-028 During RST==0 cycle, reqN_ready SHALL be 0 and no issue occurs.
REQ-029 Reset mid-LOCK1 or with a pending response SHALL discard both; no response emitted after reset.

Verification
REQ-030 Single add: req0 op0 a=32'h7FFF_FFFF b=1, rsp_ready=1 -> next cycle rsp_valid=1, id=0, result=32'h8000_0000, OF=1, SF=1, CF=0, AF=1.
REQ-031 Tie/fairness: both valid continuously 6 cycles after reset, rsp_ready=1 -> grant order 0,1,0,1,0,1, rsp_valid never drops.
REQ-032 Backpressure: response pending, rsp_ready=0 for 3 cycles -> both readys 0, rsp_* and flags_q constant; rsp_ready=1 -> issue same cycle, no bubble.
REQ-033 Lock: req1 issues with lock=1, req0 valid throughout -> req0_ready=0 for 3 further req1 beats; req1 beat with lock=0 -> next grant goes to req0.
REQ-034 Flag chaining: req0 op0 a=8'h38 b=8'h45 then op3 -> second result[7:0]=8'h83, AF=0, CF=0.
REQ-035 Reset mid-operation: RST=0 while LOCK1 and rsp_valid=1 -> next cycle rsp_valid=0, flags_q=32'h2, req0 granted first.
